// File: rtl/axi_rd_arbiter.sv
// Two-master / two-slave AXI read-path arbiter with round-robin grant, address decode and default-slave DECERR.
// Optional burst-length checking is enabled by defining AXI_RD_LEN_CHECK_EN.
module axi_rd_arbiter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             ARVALID_M0,
  input  logic             ARVALID_M1,
  input  logic [31:0]      ARADDR_M0,
  input  logic [31:0]      ARADDR_M1,
  input  logic [LEN_W-1:0] ARLEN_M0,
  input  logic [LEN_W-1:0] ARLEN_M1,
  input  logic             ARREADY_S0,
  input  logic             ARREADY_S1,
  input  logic             RVALID_S0,
  input  logic             RVALID_S1,
  input  logic             RLAST_S0,
  input  logic             RLAST_S1,
  input  logic             RREADY_M0,
  input  logic             RREADY_M1,
  output logic             grant_m0,
  output logic             grant_m1,
  output logic [1:0]       sel_s,
  output logic             busy,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             ds_active,
  output logic             len_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] SEL_S0 = 2'd0;
  localparam logic [1:0] SEL_S1 = 2'd1;
  localparam logic [1:0] SEL_DS = 2'd2;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             busy_q, busy_d;
  logic             ds_q, ds_d;
  logic             last_q, last_d;

  logic             win_m1_c;
  logic [15:0]      win_hi_c;
  logic [1:0]       dec_c;
  logic             arvalid_g_c;
  logic             arready_s_c;
  logic             rvalid_s_c;
  logic             rlast_s_c;
  logic             rready_g_c;
  logic             ar_hs_c;
  logic             beat_fire_c;
  logic             unused_addr_lo;

  assign unused_addr_lo = ^{ARADDR_M0[15:0], ARADDR_M1[15:0]};

  // Arbitration, decode and selected-channel muxing
  always_comb begin
    win_m1_c    = ARVALID_M1 & (~ARVALID_M0 | ~last_q);
    win_hi_c    = win_m1_c ? ARADDR_M1[31:16] : ARADDR_M0[31:16];
    if (win_hi_c == 16'h0000)      dec_c = SEL_S0;
    else if (win_hi_c == 16'h0001) dec_c = SEL_S1;
    else                           dec_c = SEL_DS;

    arvalid_g_c = grant_q[1] ? ARVALID_M1 : ARVALID_M0;
    rready_g_c  = grant_q[1] ? RREADY_M1  : RREADY_M0;

    arready_s_c = 1'b1;
    rvalid_s_c  = 1'b1;
    rlast_s_c   = (beat_q == '0);
    case (sel_q)
      SEL_S0: begin
        arready_s_c = ARREADY_S0;
        rvalid_s_c  = RVALID_S0;
        rlast_s_c   = RLAST_S0;
      end
      SEL_S1: begin
        arready_s_c = ARREADY_S1;
        rvalid_s_c  = RVALID_S1;
        rlast_s_c   = RLAST_S1;
      end
      default: ;
    endcase

    ar_hs_c     = arvalid_g_c & arready_s_c;
    beat_fire_c = rvalid_s_c & rready_g_c;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    len_d   = len_q;
    beat_d  = beat_q;
    busy_d  = busy_q;
    ds_d    = ds_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (ARVALID_M0 | ARVALID_M1) begin
          state_d = ST_ADDR;
          grant_d = win_m1_c ? 2'b10 : 2'b01;
          sel_d   = dec_c;
          len_d   = win_m1_c ? ARLEN_M1 : ARLEN_M0;
          busy_d  = 1'b1;
          ds_d    = (dec_c == SEL_DS);
        end
      end
      ST_ADDR: begin
        if (ar_hs_c) begin
          state_d = ST_DATA;
          beat_d  = len_q;
        end
      end
      ST_DATA: begin
        if (beat_fire_c) begin
          if (rlast_s_c) begin
            state_d = ST_IDLE;
            last_d  = grant_q[1];
            grant_d = 2'b00;
            sel_d   = SEL_S0;
            beat_d  = '0;
            busy_d  = 1'b0;
            ds_d    = 1'b0;
          end else if (beat_q != '0) begin
            beat_d = beat_q - LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        sel_d   = SEL_S0;
        beat_d  = '0;
        busy_d  = 1'b0;
        ds_d    = 1'b0;
      end
    endcase
  end

`ifdef AXI_RD_LEN_CHECK_EN
  logic len_err_q, len_err_d;

  // A beat is malformed when RLAST disagrees with the remaining-beat count
  always_comb begin
    len_err_d = 1'b0;
    if (state_q == ST_DATA && beat_fire_c)
      len_err_d = rlast_s_c ^ (beat_q == '0);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) len_err_q <= 1'b0;
    else          len_err_q <= len_err_d;
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      sel_q   <= SEL_S0;
      len_q   <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      ds_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      ds_q    <= ds_d;
      last_q  <= last_d;
    end
  end

  assign grant_m0  = grant_q[0];
  assign grant_m1  = grant_q[1];
  assign sel_s     = sel_q;
  assign busy      = busy_q;
  assign beat_cnt  = beat_q;
  assign ds_active = ds_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed, table-driven bench for axi_rd_arbiter; len_err expectations follow AXI_RD_LEN_CHECK_EN.
module tb_axi_rd_arbiter;

  localparam logic LE =
`ifdef AXI_RD_LEN_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  localparam logic [15:0] H0 = 16'h0000;
  localparam logic [15:0] H1 = 16'h0001;
  localparam logic [15:0] HD = 16'h2000;

  logic        ACLK, ARESETn;
  logic        ARVALID_M0, ARVALID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic        ARREADY_S0, ARREADY_S1;
  logic        RVALID_S0, RVALID_S1, RLAST_S0, RLAST_S1;
  logic        RREADY_M0, RREADY_M1;
  logic        grant_m0, grant_m1, busy, ds_active, len_err;
  logic [1:0]  sel_s;
  logic [3:0]  beat_cnt;

  int n_chk;
  int n_pass;

  axi_rd_arbiter #(.LEN_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
    .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
    .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1),
    .RVALID_S0(RVALID_S0), .RVALID_S1(RVALID_S1),
    .RLAST_S0(RLAST_S0), .RLAST_S1(RLAST_S1),
    .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
    .grant_m0(grant_m0), .grant_m1(grant_m1), .sel_s(sel_s), .busy(busy),
    .beat_cnt(beat_cnt), .ds_active(ds_active), .len_err(len_err)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  typedef struct {
    logic [1:0]  arv;
    logic [15:0] a0, a1;
    logic [3:0]  l0, l1;
    logic [1:0]  ardy, rv, rl, rr;
    logic [1:0]  egnt, esel;
    logic        ebusy;
    logic [3:0]  ebeat;
    logic        eds, ele;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [1:0] arv, input logic [15:0] a0, input logic [15:0] a1,
    input logic [3:0] l0, input logic [3:0] l1,
    input logic [1:0] ardy, input logic [1:0] rv, input logic [1:0] rl, input logic [1:0] rr,
    input logic [1:0] egnt, input logic [1:0] esel, input logic ebusy,
    input logic [3:0] ebeat, input logic eds, input logic ele);
    vec_t v;
    v.arv = arv; v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1;
    v.ardy = ardy; v.rv = rv; v.rl = rl; v.rr = rr;
    v.egnt = egnt; v.esel = esel; v.ebusy = ebusy; v.ebeat = ebeat;
    v.eds = eds; v.ele = ele;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    ARVALID_M0 = v.arv[0];        ARVALID_M1 = v.arv[1];
    ARADDR_M0  = {v.a0, 16'h0100}; ARADDR_M1  = {v.a1, 16'h0000};
    ARLEN_M0   = v.l0;            ARLEN_M1   = v.l1;
    ARREADY_S0 = v.ardy[0];       ARREADY_S1 = v.ardy[1];
    RVALID_S0  = v.rv[0];         RVALID_S1  = v.rv[1];
    RLAST_S0   = v.rl[0];         RLAST_S1   = v.rl[1];
    RREADY_M0  = v.rr[0];         RREADY_M1  = v.rr[1];
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] egnt, input logic [1:0] esel,
                       input logic ebusy, input logic [3:0] ebeat, input logic eds, input logic ele);
    logic [10:0] act, exp;
    act = {grant_m1, grant_m0, sel_s, busy, beat_cnt, ds_active, len_err};
    exp = {egnt, esel, ebusy, ebeat, eds, ele};
    n_chk++;
    if (act === exp) n_pass++;
    else
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b beat=%0d ds=%b lerr=%b, want gnt=%b sel=%0d busy=%b beat=%0d ds=%b lerr=%b",
               name, {grant_m1, grant_m0}, sel_s, busy, beat_cnt, ds_active, len_err,
               egnt, esel, ebusy, ebeat, eds, ele);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    ARESETn = 1'b1;
    apply(mk(2'b00, H0, H0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));

    // arv, a0, a1, l0, l1, ardy, rv, rl, rr | gnt, sel, busy, beat, ds, lerr
    // Both masters to S0, ARLEN=3: M0 first, then M1
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'd0, 1'b1, 4'd3, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b01, 2'b00, 2'b11, 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'd0, 1'b1, 4'd3, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10, 2'd0, 1'b1, 4'd1, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd3, 4'd3, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    // Continuous contention with single-beat bursts: M0 then M1 again
    tbl.push_back(mk(2'b11, H0, H0, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd0, 4'd0, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b11, H0, H0, 4'd0, 4'd0, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    // M0 to default slave, ARLEN=2, with one stall from the wrong master's ready
    tbl.push_back(mk(2'b01, HD, H0, 4'd2, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'd2, 1'b1, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(2'b01, HD, H0, 4'd2, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'd2, 1'b1, 4'd2, 1'b1, 1'b0));
    tbl.push_back(mk(2'b00, HD, H0, 4'd2, 4'd0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'd2, 1'b1, 4'd2, 1'b1, 1'b0));
    tbl.push_back(mk(2'b00, HD, H0, 4'd2, 4'd0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'd2, 1'b1, 4'd1, 1'b1, 1'b0));
    tbl.push_back(mk(2'b00, HD, H0, 4'd2, 4'd0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'd2, 1'b1, 4'd0, 1'b1, 1'b0));
    tbl.push_back(mk(2'b00, HD, H0, 4'd2, 4'd0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    // M1 to S1, ARLEN=0, ARREADY_S1 held off 4 cycles, ARVALID dropped once
    tbl.push_back(mk(2'b10, H0, H1, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, H0, H1, 4'd0, 4'd0, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, H0, H1, 4'd0, 4'd0, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, H0, H1, 4'd0, 4'd0, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, H0, H1, 4'd0, 4'd0, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b10, H0, H1, 4'd0, 4'd0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, H0, H1, 4'd0, 4'd0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'd1, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, H0, H1, 4'd0, 4'd0, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    // S0 ends an ARLEN=3 burst early on beat 2
    tbl.push_back(mk(2'b01, H0, H0, 4'd3, 4'd0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b01, H0, H0, 4'd3, 4'd0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'd0, 1'b1, 4'd3, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, H0, H0, 4'd3, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, H0, H0, 4'd3, 4'd0, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, LE));
    tbl.push_back(mk(2'b00, H0, H0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    // S0 overruns an ARLEN=0 burst by one beat
    tbl.push_back(mk(2'b01, H0, H0, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b01, H0, H0, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, H0, H0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, LE));
    tbl.push_back(mk(2'b00, H0, H0, 4'd0, 4'd0, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    tbl.push_back(mk(2'b00, H0, H0, 4'd0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));

    #2 ARESETn = 1'b0;
    #1 check("reset_async", 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    check("reset_hold", 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    ARESETn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      step();
      check($sformatf("vec%0d", i), tbl[i].egnt, tbl[i].esel, tbl[i].ebusy,
            tbl[i].ebeat, tbl[i].eds, tbl[i].ele);
    end

    // Reset mid-burst in DATA with beat_cnt=2; last_grant is M0 here, so M0 winning proves it was reset
    apply(mk(2'b01, H0, H0, 4'd2, 4'd0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    step();
    check("mid_addr", 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    step();
    check("mid_data", 2'b01, 2'd0, 1'b1, 4'd2, 1'b0, 1'b0);
    ARVALID_M0 = 1'b0;
    #3 ARESETn = 1'b0;
    #1 check("mid_reset_async", 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    check("mid_reset_hold", 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    apply(mk(2'b11, H0, H0, 4'd1, 4'd1, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0));
    ARESETn = 1'b1;
    step();
    check("post_reset_contend", 2'b01, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter: LEN_W, 4, burst length field width; matches the AXI_LEN_BITS define.
REQ-002 ACLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 ARESETn  input  1  reset, asynchronous and active-low.
REQ-004 ARVALID_M0 / ARVALID_M1  input  1 each  read-address request from master 0 / master 1.
REQ-005 ARADDR_M0 / ARADDR_M1  input  32 each  request address, used for slave decode.
REQ-006 ARLEN_M0 / ARLEN_M1  input  LEN_W each  burst length minus one.
REQ-007 ARREADY_S0 / ARREADY_S1  input  1 each  address-ready from slave 0 / slave 1.
REQ-008 RVALID_S0, RVALID_S1, RLAST_S0, RLAST_S1  input  1 each  read-data valid and last from each slave.
REQ-009 RREADY_M0 / RREADY_M1  input  1 each  read-data ready from each master.
REQ-010 grant_m0 / grant_m1  output  1 each  selects the master owning the read path; one-hot or zero.
REQ-011 sel_s  output  2  target: 0=S0, 1=S1, 2=default slave (DS); 3 is never driven.
REQ-012 busy  output  1  transaction in progress (state is not IDLE).
REQ-013 beat_cnt  output  LEN_W  beats remaining after the current beat.
REQ-014 ds_active  output  1  the read mux returns RVALID=1 and RRESP=DECERR from the default slave; RLAST is driven when beat_cnt==0.
REQ-015 len_err  output  1  burst-length violation pulse.

Function
REQ-016 The FSM has three states: IDLE, ADDR and DATA.
REQ-017 Arbitration in IDLE:
- One requester valid: that master wins.
- Both valid: the master other than last_grant wins (round-robin).
REQ-018 In IDLE, with any request valid, the block registers the winner's grant, ARLEN and decode, then moves to ADDR on the next edge.
REQ-019 Slave decode uses ARADDR[31:16]: 0x0000 selects S0, 0x0001 selects S1, any other value selects DS.
REQ-020 In ADDR, the address handshake is ARVALID of the granted master AND ARREADY of the selected slave.
- DS counts as always-ready, so ADDR lasts exactly one cycle for DS.
- On the handshake: go to DATA and load beat_cnt with the latched ARLEN.
REQ-021 In DATA, a beat is the selected RVALID AND the granted master's RREADY.
- For DS, RVALID is treated as 1.
- Each beat with beat_cnt>0 decrements beat_cnt; beat_cnt never wraps below 0.
REQ-022 A beat with the selected RLAST returns the FSM to IDLE on the next edge.
- At that edge: last_grant takes the finished master's index; grant, sel_s, beat_cnt and ds_active clear.
- For DS, RLAST is taken as (beat_cnt==0).
REQ-023 Minimum burst occupancy is ARLEN+3 cycles (IDLE, ADDR, DATA). A new grant is issued no earlier than the cycle after return to IDLE.
REQ-024 The grant is stable for the whole transaction; requests arriving mid-transaction wait.
- A request dropped before its ADDR handshake does not abort the transaction; the block stays in ADDR.
REQ-025 ds_active = (sel_s==2) AND the state is ADDR or DATA.

Reset
REQ-026 Asserting ARESETn low at any time, including mid-burst, immediately forces:
- state=IDLE, grant_m0=grant_m1=0, sel_s=0, busy=0, beat_cnt=0, ds_active=0, len_err=0;
- last_grant=1, so M0 wins the first contention.
REQ-027 After deassertion, the first arbitration occurs on the first rising edge that samples ARESETn high.

Configuration
REQ-028 Macro AXI_RD_LEN_CHECK_EN.
- Defined: len_err pulses high for exactly one cycle after either (a) a beat with RLAST while beat_cnt>0, or (b) a beat with beat_cnt==0 and no RLAST. Termination still follows RLAST only.
- Undefined: len_err is constant 0 and no check logic is present.

Verification
REQ-029 Reset, then M0 and M1 both request S0 (0x0000_0100, ARLEN=3) -> M0 granted; M0 burst takes 6 cycles from grant; then M1 is granted.
REQ-030 M1 requests 0x0001_0000 with ARLEN=0 and ARREADY_S1 delayed 4 cycles -> sel_s=1; ADDR held 5 cycles; 1 beat; return to IDLE.
REQ-031 M0 requests 0x2000_0000 with ARLEN=2 -> sel_s=2; ds_active=1 for 4 cycles; 3 DECERR beats; RLAST on the third beat.
REQ-032 Both masters request continuously for 4 bursts -> grants alternate M0, M1, M0, M1.
REQ-033 ARESETn pulled low in DATA with beat_cnt=2 -> all outputs reach their reset values immediately; the next contention grants M0.
REQ-034 With AXI_RD_LEN_CHECK_EN defined, S0 asserts RLAST on beat 2 of an ARLEN=3 burst -> len_err=1 for one cycle; FSM returns to IDLE.
